// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame controller: defaults, FSM encoding,
// and the start-request admission check.
package spi_pkg;

    localparam int DEPTH_DEFAULT    = 8;
    localparam int CS_SETUP_DEFAULT = 4;
    localparam int CS_HOLD_DEFAULT  = 4;

    // Width of the shared setup/hold cycle timer
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // A frame may start only if it asks for at least one byte and the
    // FIFO already holds every byte it will send.
    function automatic logic len_ok(input logic [3:0] len, input logic [3:0] count);
        return (len != 4'd0) && (len <= count);
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// First-word fall-through TX byte FIFO. The head entry is always visible
// on o_rd_data; i_rd pops it. Writes while full and reads while empty are
// ignored.
module spi_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr,
    input  logic [7:0]                 i_wr_data,
    input  logic                       i_rd,
    output logic [7:0]                 o_rd_data,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok;
    logic          rd_ok;

    // Qualify requests and compute next pointers/occupancy; pointers wrap naturally
    always_comb begin
        wr_ok    = i_wr && !o_full;
        rd_ok    = i_rd && (count_q != '0);
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[rd_ptr_q];
    assign o_full    = (count_q == CW'(DEPTH));
    assign o_count   = count_q;

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: buffers TX bytes, and on request frames i_Len bytes
// with chip select, handing one byte at a time to an external byte engine
// and forwarding each received byte.
module spi_frame_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int CS_SETUP = CS_SETUP_DEFAULT,
    parameter int CS_HOLD  = CS_HOLD_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_Wr_En,
    input  logic [7:0] i_Wr_Data,
    output logic       o_Full,
    output logic [3:0] o_Count,
    input  logic       i_Start,
    input  logic [3:0] i_Len,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Err,
    output logic [7:0] o_Spi_Data,
    output logic       o_Spi_Valid,
    input  logic       i_Spi_Ready,
    input  logic [7:0] i_Spi_Rx_Data,
    input  logic       i_Spi_Rx_Valid,
    output logic [7:0] o_Rx_Data,
    output logic       o_Rx_Valid,
    output logic       o_CS_n
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [3:0]           rem_q, rem_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 fifo_pop;
    logic [CW-1:0]        fifo_count;

    spi_tx_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr      (i_Wr_En),
        .i_wr_data (i_Wr_Data),
        .i_rd      (fifo_pop),
        .o_rd_data (o_Spi_Data),
        .o_full    (o_Full),
        .o_count   (fifo_count)
    );

    assign o_Count = 4'(fifo_count);

    // State and datapath registers; reset aborts any frame with no done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Next-state logic: admission, CS setup/hold timing, byte/RX sequencing
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rem_d      = rem_q;
        err_d      = 1'b0;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    if (len_ok(i_Len, o_Count)) begin
                        state_d = ST_SETUP;
                        rem_d   = i_Len;
                        timer_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                // Timer runs 0..CS_SETUP so the first byte is offered CS_SETUP+1 cycles after CS falls
                if (timer_q == TIMER_W'(CS_SETUP)) begin
                    state_d = ST_SEND;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_SEND: begin
                if (i_Spi_Ready) begin
                    state_d = ST_WAIT_RX;
                end
            end
            ST_WAIT_RX: begin
                if (i_Spi_Rx_Valid) begin
                    rx_data_d  = i_Spi_Rx_Data;
                    rx_valid_d = 1'b1;
                    rem_d      = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_HOLD: begin
                if (timer_q == TIMER_W'(CS_HOLD - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        o_Spi_Valid = (state_q == ST_SEND);
        fifo_pop    = (state_q == ST_SEND) && i_Spi_Ready;
        o_CS_n      = (state_q == ST_IDLE);
        o_Busy      = (state_q != ST_IDLE);
        o_Err       = err_q;
        o_Done      = done_q;
        o_Rx_Valid  = rx_valid_q;
        o_Rx_Data   = rx_data_q;
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: a vector table for FIFO fill and
// start admission, then hand-written frame sequences and a mid-frame reset.
module tb_spi_frame_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_Wr_En = 1'b0;
    logic [7:0] i_Wr_Data = 8'h00;
    logic       o_Full;
    logic [3:0] o_Count;
    logic       i_Start = 1'b0;
    logic [3:0] i_Len = 4'd0;
    logic       o_Busy, o_Done, o_Err;
    logic [7:0] o_Spi_Data;
    logic       o_Spi_Valid;
    logic       i_Spi_Ready = 1'b0;
    logic [7:0] i_Spi_Rx_Data = 8'h00;
    logic       i_Spi_Rx_Valid = 1'b0;
    logic [7:0] o_Rx_Data;
    logic       o_Rx_Valid;
    logic       o_CS_n;

    int errors = 0;
    int checks = 0;
    logic [7:0] model[$];

    spi_frame_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_Wr_En        (i_Wr_En),
        .i_Wr_Data      (i_Wr_Data),
        .o_Full         (o_Full),
        .o_Count        (o_Count),
        .i_Start        (i_Start),
        .i_Len          (i_Len),
        .o_Busy         (o_Busy),
        .o_Done         (o_Done),
        .o_Err          (o_Err),
        .o_Spi_Data     (o_Spi_Data),
        .o_Spi_Valid    (o_Spi_Valid),
        .i_Spi_Ready    (i_Spi_Ready),
        .i_Spi_Rx_Data  (i_Spi_Rx_Data),
        .i_Spi_Rx_Valid (i_Spi_Rx_Valid),
        .o_Rx_Data      (o_Rx_Data),
        .o_Rx_Valid     (o_Rx_Valid),
        .o_CS_n         (o_CS_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       start;
        logic [3:0] len;
        logic [3:0] exp_count;
        logic       exp_full;
        logic       exp_err;
        logic       exp_cs_n;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d);
        i_Wr_En = 1'b1;
        i_Wr_Data = d;
        @(negedge clk);
        i_Wr_En = 1'b0;
        if (model.size() < 8) model.push_back(d);
    endtask

    // One full frame with engine emulation; optional stall on the first
    // byte and optional FIFO write in the same cycle as every pop.
    task automatic run_frame(input int len, input int stall, input bit wrpop, input logic [7:0] wbase);
        int cyc;
        int k;
        bit spurious;
        bit err_seen;
        bit stall_ok;
        logic [7:0] exp_b;
        logic [7:0] held;
        logic [3:0] cnt0;
        i_Start = 1'b1;
        i_Len = 4'(len);
        @(negedge clk);
        i_Start = 1'b0;
        chk("cs_low_latency", 32'(o_CS_n), 32'd0);
        chk("busy_set", 32'(o_Busy), 32'd1);
        cyc = 0;
        spurious = 0;
        err_seen = 0;
        while (!o_Spi_Valid && cyc < 40) begin
            i_Spi_Rx_Valid = (cyc == 1);
            i_Spi_Rx_Data = 8'hEE;
            i_Start = (cyc == 2);
            i_Len = 4'd1;
            @(negedge clk);
            cyc++;
            if (o_Rx_Valid) spurious = 1;
            if (o_Err) err_seen = 1;
        end
        i_Spi_Rx_Valid = 1'b0;
        i_Start = 1'b0;
        chk("setup_cycles", 32'(cyc), 32'(CS_SETUP_DEFAULT + 1));
        chk("rx_outside_wait_ignored", 32'(spurious), 32'd0);
        chk("start_while_busy_no_err", 32'(err_seen), 32'd0);
        for (int i = 0; i < len; i++) begin
            k = 0;
            while (!o_Spi_Valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("spi_valid_wait", 32'(o_Spi_Valid), 32'd1);
            exp_b = (model.size() > 0) ? model.pop_front() : 8'h00;
            chk("spi_data", 32'(o_Spi_Data), 32'(exp_b));
            if (i == 0 && stall > 0) begin
                held = o_Spi_Data;
                cnt0 = o_Count;
                stall_ok = 1;
                repeat (stall) begin
                    @(negedge clk);
                    if (!o_Spi_Valid || o_Spi_Data !== held || o_Count !== cnt0) stall_ok = 0;
                end
                chk("stall_stable", 32'(stall_ok), 32'd1);
            end
            cnt0 = o_Count;
            i_Spi_Ready = 1'b1;
            if (wrpop) begin
                i_Wr_En = 1'b1;
                i_Wr_Data = wbase + 8'(i);
            end
            @(negedge clk);
            i_Spi_Ready = 1'b0;
            i_Wr_En = 1'b0;
            if (wrpop) model.push_back(wbase + 8'(i));
            chk("valid_low_in_wait_rx", 32'(o_Spi_Valid), 32'd0);
            chk("count_after_pop", 32'(o_Count), wrpop ? 32'(cnt0) : 32'(cnt0 - 4'd1));
            @(negedge clk);
            i_Spi_Rx_Valid = 1'b1;
            i_Spi_Rx_Data = 8'hC0 ^ exp_b;
            @(negedge clk);
            i_Spi_Rx_Valid = 1'b0;
            chk("rx_valid", 32'(o_Rx_Valid), 32'd1);
            chk("rx_data", 32'(o_Rx_Data), 32'(8'hC0 ^ exp_b));
        end
        k = 0;
        while (!o_Done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("hold_cycles", 32'(k), 32'(CS_HOLD_DEFAULT));
        chk("cs_high_at_done", 32'(o_CS_n), 32'd1);
        chk("busy_clear_at_done", 32'(o_Busy), 32'd0);
        @(negedge clk);
        chk("done_single_pulse", 32'(o_Done), 32'd0);
        chk("count_after_frame", 32'(o_Count), 32'(model.size()));
        $display("frame len=%0d stall=%0d wrpop=%0d count=%0d errors=%0d", len, stall, wrpop, o_Count, errors);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit done_seen;
        bit cs_bad;
        // Table: FIFO fill and start admission, one cycle per row
        vecs[0] = '{1'b0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 8'h01, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 4'd3, 4'd1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h02, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'h03, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'h04, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'h06, 1'b0, 4'd0, 4'd6, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'h07, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 8'h08, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 8'h09, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1};

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        chk("rst_cs_n", 32'(o_CS_n), 32'd1);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_done_err", 32'({o_Done, o_Err}), 32'd0);
        chk("rst_valids", 32'({o_Spi_Valid, o_Rx_Valid}), 32'd0);
        chk("rst_rx_data", 32'(o_Rx_Data), 32'd0);
        chk("rst_count", 32'(o_Count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            i_Wr_En = vecs[i].wr;
            i_Wr_Data = vecs[i].d;
            i_Start = vecs[i].start;
            i_Len = vecs[i].len;
            @(negedge clk);
            i_Wr_En = 1'b0;
            i_Start = 1'b0;
            if (vecs[i].wr && model.size() < 8) model.push_back(vecs[i].d);
            chk("vec_count", 32'(o_Count), 32'(vecs[i].exp_count));
            chk("vec_full", 32'(o_Full), 32'(vecs[i].exp_full));
            chk("vec_err", 32'(o_Err), 32'(vecs[i].exp_err));
            chk("vec_cs_n", 32'(o_CS_n), 32'(vecs[i].exp_cs_n));
            $display("vec %0d wr=%0d d=%02h start=%0d len=%0d -> count=%0d full=%0d err=%0d cs_n=%0d",
                     i, vecs[i].wr, vecs[i].d, vecs[i].start, vecs[i].len, o_Count, o_Full, o_Err, o_CS_n);
        end

        // Read out 1..8 in order with a 10-cycle engine stall on the first byte
        run_frame(8, 10, 1'b0, 8'h00);

        // Basic two-byte frame
        wr_byte(8'hA5);
        wr_byte(8'h3C);
        run_frame(2, 0, 1'b0, 8'h00);

        // Simultaneous push/pop; write pointer wraps past the last entry
        for (int i = 0; i < 6; i++) wr_byte(8'h61 + 8'(i));
        run_frame(6, 0, 1'b1, 8'h71);
        run_frame(6, 0, 1'b0, 8'h00);

        // Reset in WAIT_RX of a 4-byte frame
        for (int i = 0; i < 4; i++) wr_byte(8'h90 + 8'(i));
        i_Start = 1'b1;
        i_Len = 4'd4;
        @(negedge clk);
        i_Start = 1'b0;
        k = 0;
        while (!o_Spi_Valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_test_valid_wait", 32'(o_Spi_Valid), 32'd1);
        i_Spi_Ready = 1'b1;
        @(negedge clk);
        i_Spi_Ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_rst_cs_n", 32'(o_CS_n), 32'd1);
        chk("midframe_rst_count", 32'(o_Count), 32'd0);
        chk("midframe_rst_busy", 32'(o_Busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model.delete();
        done_seen = 0;
        cs_bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (o_Done) done_seen = 1;
            if (!o_CS_n) cs_bad = 1;
        end
        chk("midframe_rst_no_done", 32'(done_seen), 32'd0);
        chk("midframe_rst_cs_stays_high", 32'(cs_bad), 32'd0);
        $display("reset abort: cs_n=%0d count=%0d", o_CS_n, o_Count);

        // FIFO usable after flush
        wr_byte(8'h5A);
        run_frame(1, 0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 The block SHALL have parameters: DEPTH, 8, TX FIFO entries (power of two); CS_SETUP, 4, i_clk cycles from CS_n low to first byte; CS_HOLD, 4, i_clk cycles from last RX byte to CS_n high.
REQ-002 Ports SHALL be: i_clk  in  1  sole clock; i_rst_n  in  1  asynchronous active-low reset.
REQ-003 i_Wr_En  in  1  push i_Wr_Data into TX FIFO; i_Wr_Data  in  8  TX byte; o_Full  out  1  FIFO full; o_Count  out  4  FIFO occupancy (0..DEPTH).
REQ-004 i_Start  in  1  one-cycle frame request; i_Len  in  4  frame length in bytes; o_Busy  out  1  frame active; o_Done  out  1  one-cycle frame-complete pulse; o_Err  out  1  one-cycle rejected-start pulse.
REQ-005 o_Spi_Data  out  8  byte to SPI byte engine; o_Spi_Valid  out  1  byte offered; i_Spi_Ready  in  1  engine accepts byte.
REQ-006 i_Spi_Rx_Data  in  8  byte received by engine; i_Spi_Rx_Valid  in  1  one-cycle RX byte strobe.
REQ-007 o_Rx_Data  out  8  received byte; o_Rx_Valid  out  1  one-cycle strobe; o_CS_n  out  1  slave select, active low.

Function
REQ-008 TX FIFO: write when i_Wr_En and not o_Full; write while full SHALL be dropped, contents unchanged.
REQ-009 FIFO read SHALL occur only on o_Spi_Valid and i_Spi_Ready in the same cycle; simultaneous write and read SHALL leave o_Count unchanged.
REQ-010 Pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0; o_Full when o_Count==DEPTH.
REQ-011 FSM states: IDLE, SETUP, SEND, WAIT_RX, HOLD.
REQ-012 IDLE: i_Start with 1<=i_Len<=o_Count SHALL latch i_Len, set o_Busy, drive o_CS_n low, go to SETUP next cycle.
REQ-013 IDLE: i_Start with i_Len==0 or i_Len>o_Count SHALL pulse o_Err next cycle and remain IDLE; i_Start while o_Busy SHALL be ignored with no o_Err.
REQ-014 SETUP: count CS_SETUP cycles, then SEND.
REQ-015 SEND: o_Spi_Valid=1, o_Spi_Data=FIFO head (first-word fall-through); on i_Spi_Ready pop and go to WAIT_RX.
REQ-016 WAIT_RX: on i_Spi_Rx_Valid copy i_Spi_Rx_Data to o_Rx_Data, pulse o_Rx_Valid next cycle, decrement remaining count; remaining >0 -> SEND, else HOLD.
REQ-017 i_Spi_Rx_Valid outside WAIT_RX SHALL be ignored.
REQ-018 HOLD: count CS_HOLD cycles, then o_CS_n high, o_Busy low, o_Done pulse for one cycle, IDLE.
REQ-019 Latency: i_Start to o_CS_n low 1 cycle; o_CS_n low to first o_Spi_Valid CS_SETUP+1 cycles.
REQ-020 FIFO writes SHALL remain permitted during a frame.
REQ-021 o_Spi_Valid SHALL be 0 in all states except SEND.

Reset
REQ-022 Asserting i_rst_n low SHALL immediately force: o_CS_n=1, o_Busy=0, o_Done=0, o_Err=0, o_Spi_Valid=0, o_Rx_Valid=0, o_Rx_Data=0, o_Count=0, pointers=0, state IDLE.
REQ-023 Reset mid-frame SHALL abort the frame and flush the FIFO, with no o_Done.
REQ-024 Reset release SHALL take effect on the next i_clk rising edge.

Structure
REQ-025 FSM state encodings and default DEPTH/CS_SETUP/CS_HOLD values SHALL reside in shared package spi_pkg.
REQ-026 The TX FIFO SHALL be sub-module spi_tx_fifo, with write/read/full/count ports only.

Verification
REQ-027 Write 0xA5,0x3C; i_Start with i_Len=2 -> o_CS_n low, o_Spi_Data 0xA5 then 0x3C, two o_Rx_Valid echoing engine bytes, o_Done once, o_Count=0.
REQ-028 Write 9 bytes at DEPTH=8 -> o_Full after 8th, 9th dropped, o_Count=8, readout 1..8 in order.
REQ-029 o_Count=1, i_Start with i_Len=3 -> o_Err pulse, o_CS_n stays high; i_Len=0 -> o_Err.
REQ-030 Drive simultaneous write and pop in SEND -> o_Count unchanged; pointers wrap past 7 with correct data order.
REQ-031 Assert i_rst_n low in WAIT_RX of a 4-byte frame -> o_CS_n high, o_Count=0 immediately; no o_Done.
REQ-032 Hold i_Spi_Ready low 10 cycles in SEND -> o_Spi_Valid and o_Spi_Data stable, no pop.
